// File: rtl/alu_op_responder.sv
// Sequential 8-bit ALU responder: valid/ready request in, valid/ready result out.
// Single-cycle ops run in EXEC; MUL is an iterative shift-add over WIDTH cycles.
module alu_op_responder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [SW-1:0]      sh;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     shr;
  logic               accept;

  // In RESP a new request may only enter alongside the result handshake.
  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    end
  end

  assign accept = req_valid && req_ready;
  assign busy   = (state == EXEC) || (state == MUL);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sh        = b_q[SW-1:0];
    shl       = '0;
    shr       = '0;
    case (op_q)
      3'd0: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      3'd1: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      3'd2: alu_res = a_q & b_q;
      3'd3: alu_res = a_q | b_q;
      3'd4: alu_res = a_q ^ b_q;
      // The extra bit beside the operand catches the last bit shifted out.
      3'd5: begin
        shl       = {1'b0, a_q} << sh;
        alu_res   = shl[WIDTH-1:0];
        alu_carry = shl[WIDTH];
      end
      3'd6: begin
        shr       = {a_q, 1'b0} >> sh;
        alu_res   = shr[WIDTH:1];
        alu_carry = shr[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else if (accept) begin
      a_q       <= req_a;
      b_q       <= req_b;
      op_q      <= req_op;
      mcand     <= {{WIDTH{1'b0}}, req_a};
      mplier    <= req_b;
      acc       <= '0;
      cnt       <= CW'(WIDTH);
      rsp_valid <= 1'b0;
      state     <= (req_op == 3'd7) ? MUL : EXEC;
    end else begin
      case (state)
        EXEC: begin
          rsp_data  <= alu_res;
          rsp_carry <= alu_carry;
          rsp_zero  <= (alu_res == '0);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          // Final iteration: publish the accumulator including this step's add.
          if (cnt == CW'(1)) begin
            rsp_data  <= acc_next[WIDTH-1:0];
            rsp_carry <= |acc_next[2*WIDTH-1:WIDTH];
            rsp_zero  <= (acc_next[WIDTH-1:0] == '0);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_responder.sv
// Directed bench for alu_op_responder: scoreboard of model results checked
// on each response handshake, plus latency, backpressure and reset checks.
module tb_alu_op_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [2:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_rsp = 0;

  alu_op_responder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int unsigned ai, bi, r, c, sh, p;
    exp_t e;
    ai = a;
    bi = b;
    sh = bi % 8;
    r  = 0;
    c  = 0;
    case (op)
      3'd0: begin r = ai + bi; c = (r > 255) ? 1 : 0; end
      3'd1: begin r = ai - bi; c = (ai < bi) ? 1 : 0; end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: begin p = ai << sh; r = p; c = (sh > 0) ? ((p >> 8) & 1) : 0; end
      3'd6: begin r = ai >> sh; c = (sh > 0) ? ((ai >> (sh - 1)) & 1) : 0; end
      default: begin p = ai * bi; r = p; c = ((p >> 8) != 0) ? 1 : 0; end
    endcase
    e.d = 8'(r & 255);
    e.c = c[0];
    e.z = ((r & 255) == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.d);
        check("rsp_carry", rsp_carry, e.c);
        check("rsp_zero", rsp_zero, e.z);
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    sb.push_back(model(a, b, op));
  endtask

  task automatic wait_accept(output int acc_cyc);
    logic hit;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      hit = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (hit) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Latency counts edges from the accept edge (as edge 1) to the edge raising rsp_valid.
  task automatic wait_rsp(output int lat, output int bz);
    logic found;
    found = 1'b0;
    lat   = 1;
    bz    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
      if (busy) bz++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!found) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, prev, lat, bz, c0, n0, seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_carry", rsp_carry, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("req_ready_after_rst", req_ready, 1);

    // ADD with carry out and latency
    rsp_ready = 1'b1;
    drive(8'hF0, 8'h20, 3'd0);
    wait_accept(acc);
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    check("add_latency", lat, 2);
    check("add_busy_cycles", bz, 1);
    check("add_data", rsp_data, 8'h10);
    check("add_carry", rsp_carry, 1);
    check("add_zero", rsp_zero, 0);
    step();
    check("idle_after_hs", rsp_valid, 0);

    drive(8'h05, 8'h07, 3'd1);
    wait_accept(acc);
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    check("sub_data", rsp_data, 8'hFE);
    check("sub_borrow", rsp_carry, 1);
    step();

    drive(8'h81, 8'h01, 3'd5);
    wait_accept(acc);
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    check("shl_data", rsp_data, 8'h02);
    check("shl_carry", rsp_carry, 1);
    step();

    drive(8'h81, 8'h03, 3'd6);
    wait_accept(acc);
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    check("shr_data", rsp_data, 8'h10);
    check("shr_carry", rsp_carry, 0);
    step();

    drive(8'h13, 8'h0B, 3'd7);
    wait_accept(acc);
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    check("mul_latency", lat, 9);
    check("mul_busy_cycles", bz, 8);
    check("mul_data", rsp_data, 8'hD1);
    check("mul_carry", rsp_carry, 0);
    step();

    drive(8'h20, 8'h10, 3'd7);
    wait_accept(acc);
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    check("mul_ovf_data", rsp_data, 8'h00);
    check("mul_ovf_carry", rsp_carry, 1);
    check("mul_ovf_zero", rsp_zero, 1);
    step();

    // Backpressure with a request waiting behind the stalled result
    rsp_ready = 1'b0;
    drive(8'hAA, 8'hFF, 3'd4);
    wait_accept(acc);
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    step();
    drive(8'h03, 8'h04, 3'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 8'h55);
      check("bp_req_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    c0 = cyc;
    wait_accept(acc);
    req_valid = 1'b0;
    check("bp_accept_edge", acc, c0 + 1);
    wait_rsp(lat, bz);
    check("bp_next_data", rsp_data, 8'h07);
    step();

    // Back-to-back ops 0..6 with random operands
    n0 = n_rsp;
    prev = 0;
    for (int k = 0; k < 7; k++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(k));
      wait_accept(acc);
      if (k > 0) check("b2b_spacing", acc - prev, 2);
      prev = acc;
    end
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    step();
    check("b2b_rsp_count", n_rsp - n0, 7);
    check("b2b_sb_empty", sb.size(), 0);

    // Reset in the middle of a MUL discards it
    req_a     = 8'hFF;
    req_b     = 8'hFF;
    req_op    = 3'd7;
    req_valid = 1'b1;
    wait_accept(acc);
    req_valid = 1'b0;
    repeat (3) step();
    check("mid_mul_busy", busy, 1);
    rst = 1'b1;
    step();
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_rsp_data", rsp_data, 0);
    check("mr_rsp_carry", rsp_carry, 0);
    check("mr_rsp_zero", rsp_zero, 0);
    check("mr_busy", busy, 0);
    check("mr_req_ready", req_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mr_no_rsp", seen, 0);
    step();

    drive(8'h01, 8'h01, 3'd0);
    wait_accept(acc);
    req_valid = 1'b0;
    wait_rsp(lat, bz);
    check("post_rst_add", rsp_data, 8'h02);
    step();
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
